bit_serial_subtractor: RTL and testbench



---
 rtl/bit_serial_subtractor.sv | 158 +++++++++++++++
 tb/tb_bit_serial_subtractor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor
// Computes diff = a - b one bit per clock, LSB first, as a + ~b + 1 through a
// single full-adder slice with a registered carry.
// start/busy/done handshake. Results stay on the outputs until the next
// operation completes or reset is asserted.
// Optional build macro BIT_SERIAL_ADD_MODE_EN adds an op input (0 = subtract,
// 1 = add). In add mode the borrow output reports the carry-out.
module bit_serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef BIT_SERIAL_ADD_MODE_EN
    input  logic             op,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int              CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [WIDTH-1:0]   shift_a;
    logic [WIDTH-1:0]   shift_b;
    // Sum bits collected so far; the final bit is joined directly when the
    // last slice result is produced, so WIDTH-1 bits of storage suffice.
    logic [WIDTH-2:0]   res_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               a_msb_q;
    logic               b_msb_q;
    logic               add_q;

    logic               add_sel;
    logic               accept;
    logic               last_bit;
    logic [1:0]         fa_out;
    logic               sum_bit;
    logic               carry_out;
    logic [WIDTH-1:0]   res_next;
    logic               borrow_next;
    logic               ovf_next;

    // One-bit full-adder slice: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        logic s;
        logic c;
        s = x ^ y ^ cin;
        c = (x & y) | (x & cin) | (y & cin);
        return {c, s};
    endfunction

`ifdef BIT_SERIAL_ADD_MODE_EN
    assign add_sel = op;
`else
    assign add_sel = 1'b0;
`endif

    assign accept    = (state_q == IDLE) && start;
    assign last_bit  = (cnt_q == LAST);

    assign fa_out    = full_add(shift_a[0], shift_b[0], carry_q);
    assign sum_bit   = fa_out[0];
    assign carry_out = fa_out[1];
    assign res_next  = {sum_bit, res_q};

    // Subtract reports borrow as the inverted carry; add reports the carry.
    assign borrow_next = add_q ? carry_out : ~carry_out;

    // Signed overflow judged from the captured operand sign bits.
    assign ovf_next = add_q
        ? ((a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q))
        : ((a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q));

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN for WIDTH edges, DONE for one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (last_bit) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and bit-serial datapath: shift operands right, collect sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_a <= '0;
            shift_b <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            add_q   <= 1'b0;
        end else if (accept) begin
            shift_a <= a;
            shift_b <= add_sel ? b : ~b;
            res_q   <= '0;
            carry_q <= ~add_sel;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            add_q   <= add_sel;
        end else if (state_q == RUN) begin
            shift_a <= {1'b0, shift_a[WIDTH-1:1]};
            shift_b <= {1'b0, shift_b[WIDTH-1:1]};
            res_q   <= res_next[WIDTH-1:1];
            carry_q <= carry_out;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Result registers: loaded only on the edge entering DONE, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if ((state_q == RUN) && last_bit) begin
            diff     <= res_next;
            borrow   <= borrow_next;
            overflow <= ovf_next;
            zero     <= (res_next == '0);
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Testbench for bit_serial_subtractor at WIDTH=8. Expected results are pushed
// to a queue when an operation is started and popped when done pulses.
module tb_bit_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         op;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;
    logic         zero;

    int vectors;
    int miscompares;

    // {diff, borrow, overflow, zero}
    logic [W+2:0] exp_q[$];
    logic [W+2:0] held;

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef BIT_SERIAL_ADD_MODE_EN
        .op       (op),
`endif
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic add);
        logic [W:0]   wide;
        logic [W-1:0] d;
        logic         brw;
        logic         ovf;
        if (add) begin
            wide = {1'b0, x} + {1'b0, y};
            d    = wide[W-1:0];
            brw  = wide[W];
            ovf  = (x[W-1] == y[W-1]) && (d[W-1] != x[W-1]);
        end else begin
            d    = x - y;
            brw  = (x < y);
            ovf  = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
        end
        return {d, brw, ovf, (d == '0)};
    endfunction

    // Result checker on the falling edge: compare on done, check hold while busy.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    held = exp_q.pop_front();
                    chk("diff",     32'(diff),     32'(held[W+2:3]));
                    chk("borrow",   32'(borrow),   32'(held[2]));
                    chk("overflow", 32'(overflow), 32'(held[1]));
                    chk("zero",     32'(zero),     32'(held[0]));
                end
            end else if (busy) begin
                chk("hold_during_run", 32'({diff, borrow, overflow, zero}), 32'(held));
            end
        end
    end

    // One operation: accept, optional disturbance mid-RUN, latency and busy-length checks.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic aop, input bit disturb);
        int edges;
        int busy_cnt;
        @(negedge clk);
        a     = ia;
        b     = ib;
        op    = aop;
        start = 1'b1;
        exp_q.push_back(model(ia, ib, aop));
        @(posedge clk);
        #1 start = 1'b0;
        edges    = 1;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            if (disturb && edges == 3) begin
                start = 1'b1;
                a     = 8'h10;
                b     = 8'h01;
            end else if (disturb && edges > 3) begin
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            @(posedge clk);
            #1 edges++;
        end
        start = 1'b0;
        chk("latency", 32'(edges), 32'(W + 1));
        chk("busy_cycles", 32'(busy_cnt), 32'(W));
        @(posedge clk);
        #1 chk("done_pulse_width", 32'(done), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        held        = '0;
        rst_n       = 1'b0;
        op          = 1'b0;
        start       = 1'b0;
        a           = '0;
        b           = '0;

        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", 32'({busy, done, diff, borrow, overflow, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(8'h05, 8'h03, 1'b0, 1'b0);
        do_op(8'h03, 8'h05, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 1'b0);
        do_op(8'h5A, 8'h5A, 1'b0, 1'b0);
        do_op(8'h00, 8'hFF, 1'b0, 1'b0);
        do_op(8'h7F, 8'hFF, 1'b0, 1'b0);
        do_op(8'hC3, 8'h3C, 1'b0, 1'b1);

        // No stray operation after the ignored start.
        repeat (4) @(posedge clk);
        #1 chk("idle_after_ignored_start", 32'({busy, done}), 32'd0);

        // Abort an operation with reset at RUN cycle 4.
        @(negedge clk);
        a     = 8'h33;
        b     = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        held = '0;
        #1 chk("reset_mid_run", 32'({busy, done, diff, borrow, overflow, zero}), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("reset_held", 32'({busy, done, diff, borrow, overflow, zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("no_done_after_abort", 32'(done), 32'd0);

        do_op(8'h09, 8'h04, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_op(W'($urandom), W'($urandom), 1'b0, 1'b0);
        end

`ifdef BIT_SERIAL_ADD_MODE_EN
        do_op(8'h7F, 8'h01, 1'b1, 1'b0);
        do_op(8'hFF, 8'h01, 1'b1, 1'b0);
        do_op(8'h80, 8'h80, 1'b1, 1'b0);
        do_op(8'h05, 8'h03, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1 chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
